// File: rtl/centroid_calc_if.sv
// Pixel-stream inputs and per-frame centroid/bbox results of centroid_calc.
// master = pixel source / result consumer, slave = centroid_calc.
interface centroid_calc_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9
);
  logic           iPix_Val;
  logic           iFrame_Start;
  logic           iMatch;
  logic [X_W-1:0] oCent_X;
  logic [Y_W-1:0] oCent_Y;
  logic           oCent_Val;
  logic           oCent_Stb;
  logic           oBusy;
  logic [X_W-1:0] oBox_Xmin;
  logic [X_W-1:0] oBox_Xmax;
  logic [Y_W-1:0] oBox_Ymin;
  logic [Y_W-1:0] oBox_Ymax;

  modport master (
    output iPix_Val, iFrame_Start, iMatch,
    input  oCent_X, oCent_Y, oCent_Val, oCent_Stb, oBusy,
    input  oBox_Xmin, oBox_Xmax, oBox_Ymin, oBox_Ymax
  );

  modport slave (
    input  iPix_Val, iFrame_Start, iMatch,
    output oCent_X, oCent_Y, oCent_Val, oCent_Stb, oBusy,
    output oBox_Xmin, oBox_Xmax, oBox_Ymin, oBox_Ymax
  );
endinterface

// File: rtl/centroid_calc.sv
// Per-frame centroid of matched pixels (bounding box when CENT_BBOX_EN is defined); result
// published DIV_ITERS+2 cycles after the last pixel; accepts one pixel per cycle, no backpressure.
module centroid_calc #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int MIN_PIXELS = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  centroid_calc_if.slave bus
);
  localparam int X_W       = $clog2(IMG_WIDTH);
  localparam int Y_W       = $clog2(IMG_HEIGHT);
  localparam int CNT_W     = $clog2(IMG_WIDTH*IMG_HEIGHT+1);
  localparam int SX_W      = X_W + CNT_W;
  localparam int SY_W      = Y_W + CNT_W;
  localparam int DIV_ITERS = (X_W > Y_W) ? X_W : Y_W;
  localparam int RW        = CNT_W + DIV_ITERS;
  localparam int IT_W      = $clog2(DIV_ITERS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, PUBLISH} state_t;

  state_t           state;
  logic             frame_live;
  logic [X_W-1:0]   x_pos;
  logic [Y_W-1:0]   y_pos;
  logic [CNT_W-1:0] cnt;
  logic [SX_W-1:0]  sum_x;
  logic [SY_W-1:0]  sum_y;
  logic [CNT_W-1:0] div_cnt;
  logic [RW-1:0]    rem_x, rem_y, dsor;
  logic [X_W-1:0]   q_x;
  logic [Y_W-1:0]   q_y;
  logic [IT_W-1:0]  iter;
  logic             pub_go, pub_ok;
  logic [X_W-1:0]   cent_x;
  logic [Y_W-1:0]   cent_y;
  logic             cent_val, cent_stb, busy;

  logic             fresh, accepting, hit, is_last;
  logic [X_W-1:0]   cur_x;
  logic [Y_W-1:0]   cur_y;
  logic [CNT_W-1:0] cnt_nxt;
  logic [SX_W-1:0]  sum_x_nxt;
  logic [SY_W-1:0]  sum_y_nxt;

  // A frame-start pixel sees cleared accumulators and position (0,0), then accumulates normally.
  always_comb begin
    fresh     = bus.iPix_Val && bus.iFrame_Start;
    accepting = bus.iPix_Val && (bus.iFrame_Start || state == ACCUM || frame_live);
    hit       = accepting && bus.iMatch;
    cur_x     = bus.iFrame_Start ? '0 : x_pos;
    cur_y     = bus.iFrame_Start ? '0 : y_pos;
    is_last   = accepting && cur_x == X_W'(IMG_WIDTH-1) && cur_y == Y_W'(IMG_HEIGHT-1);
    cnt_nxt   = (fresh ? '0 : cnt)   + (hit ? CNT_W'(1) : '0);
    sum_x_nxt = (fresh ? '0 : sum_x) + (hit ? SX_W'(cur_x) : '0);
    sum_y_nxt = (fresh ? '0 : sum_y) + (hit ? SY_W'(cur_y) : '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      frame_live <= 1'b0;
      x_pos      <= '0;
      y_pos      <= '0;
      cnt        <= '0;
      sum_x      <= '0;
      sum_y      <= '0;
      div_cnt    <= '0;
      rem_x      <= '0;
      rem_y      <= '0;
      dsor       <= '0;
      q_x        <= '0;
      q_y        <= '0;
      iter       <= '0;
      pub_go     <= 1'b0;
      pub_ok     <= 1'b0;
      cent_x     <= '0;
      cent_y     <= '0;
      cent_val   <= 1'b0;
      cent_stb   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Output stage sits one cycle behind PUBLISH.
      pub_go   <= 1'b0;
      cent_stb <= pub_go;
      if (pub_go) begin
        cent_val <= pub_ok;
        if (pub_ok) begin
          cent_x <= q_x;
          cent_y <= q_y;
        end
      end

      if (bus.iPix_Val) begin
        if (cur_x == X_W'(IMG_WIDTH-1)) begin
          x_pos <= '0;
          y_pos <= (cur_y == Y_W'(IMG_HEIGHT-1)) ? '0 : cur_y + Y_W'(1);
        end else begin
          x_pos <= cur_x + X_W'(1);
          y_pos <= cur_y;
        end
      end

      if (is_last) begin
        cnt     <= '0;
        sum_x   <= '0;
        sum_y   <= '0;
        div_cnt <= cnt_nxt;
        rem_x   <= RW'(sum_x_nxt);
        rem_y   <= RW'(sum_y_nxt);
        dsor    <= RW'(cnt_nxt) << (DIV_ITERS-1);
        q_x     <= '0;
        q_y     <= '0;
        iter    <= '0;
      end else if (accepting) begin
        cnt   <= cnt_nxt;
        sum_x <= sum_x_nxt;
        sum_y <= sum_y_nxt;
      end

      case (state)
        IDLE: if (fresh) state <= ACCUM;
        ACCUM: if (is_last) begin
          state <= DIVIDE;
          busy  <= 1'b1;
        end
        DIVIDE: begin
          // Restoring step against a pre-shifted divisor: one quotient bit per cycle, MSB first.
          if (rem_x >= dsor) rem_x <= rem_x - dsor;
          if (rem_y >= dsor) rem_y <= rem_y - dsor;
          q_x  <= (q_x << 1) | X_W'(rem_x >= dsor);
          q_y  <= (q_y << 1) | Y_W'(rem_y >= dsor);
          dsor <= dsor >> 1;
          iter <= iter + IT_W'(1);
          if (fresh) frame_live <= 1'b1;
          if (iter == IT_W'(DIV_ITERS-1)) begin
            state <= PUBLISH;
            busy  <= 1'b0;
          end
        end
        PUBLISH: begin
          pub_go     <= 1'b1;
          pub_ok     <= div_cnt >= CNT_W'(MIN_PIXELS);
          frame_live <= 1'b0;
          state      <= (frame_live || fresh) ? ACCUM : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oCent_X   = cent_x;
  assign bus.oCent_Y   = cent_y;
  assign bus.oCent_Val = cent_val;
  assign bus.oCent_Stb = cent_stb;
  assign bus.oBusy     = busy;

`ifdef CENT_BBOX_EN
  logic [X_W-1:0] bx_min, bx_max, lx_min, lx_max, ox_min, ox_max, nx_min, nx_max, bx_min_b, bx_max_b;
  logic [Y_W-1:0] by_min, by_max, ly_min, ly_max, oy_min, oy_max, ny_min, ny_max, by_min_b, by_max_b;

  always_comb begin
    bx_min_b = fresh ? '1 : bx_min;
    bx_max_b = fresh ? '0 : bx_max;
    by_min_b = fresh ? '1 : by_min;
    by_max_b = fresh ? '0 : by_max;
    nx_min   = (hit && cur_x < bx_min_b) ? cur_x : bx_min_b;
    nx_max   = (hit && cur_x > bx_max_b) ? cur_x : bx_max_b;
    ny_min   = (hit && cur_y < by_min_b) ? cur_y : by_min_b;
    ny_max   = (hit && cur_y > by_max_b) ? cur_y : by_max_b;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {bx_min, bx_max, lx_min, lx_max, ox_min, ox_max} <= '0;
      {by_min, by_max, ly_min, ly_max, oy_min, oy_max} <= '0;
    end else begin
      if (is_last) begin
        {lx_min, lx_max, ly_min, ly_max} <= {nx_min, nx_max, ny_min, ny_max};
        bx_min <= '1;
        bx_max <= '0;
        by_min <= '1;
        by_max <= '0;
      end else if (accepting) begin
        {bx_min, bx_max, by_min, by_max} <= {nx_min, nx_max, ny_min, ny_max};
      end
      if (pub_go && pub_ok) begin
        {ox_min, ox_max, oy_min, oy_max} <= {lx_min, lx_max, ly_min, ly_max};
      end
    end
  end

  assign bus.oBox_Xmin = ox_min;
  assign bus.oBox_Xmax = ox_max;
  assign bus.oBox_Ymin = oy_min;
  assign bus.oBox_Ymax = oy_max;
`else
  assign bus.oBox_Xmin = '0;
  assign bus.oBox_Xmax = '0;
  assign bus.oBox_Ymin = '0;
  assign bus.oBox_Ymax = '0;
`endif
endmodule

// File: tb/tb_centroid_calc.sv
// Directed bench for centroid_calc on an 8x4 image: a per-frame arithmetic model predicts
// every output each cycle, and literal expectations pin the key results.
module tb_centroid_calc;
  localparam int W = 8, H = 4, MINP = 2;
`ifdef CENT_BBOX_EN
  localparam bit BBOX = 1'b1;
`else
  localparam bit BBOX = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  centroid_calc_if #(.X_W(3), .Y_W(2)) bus ();
  centroid_calc #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MIN_PIXELS(MINP)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // model state
  int mx, my, mcnt, msx, msy, mxmin, mxmax, mymin, mymax;
  bit live, pend, pend_val, busy_on, chk_en;
  int pend_cyc, pend_x, pend_y, busy_t, last_t;
  int pend_bb[4];
  int e_x, e_y, e_val;
  int e_bb[4];
  int stb_seen = 0;
  int cap_x[32], cap_y[32], cap_val[32], cap_cyc[32], cap_xmin[32], cap_ymax[32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mcnt = 0; msx = 0; msy = 0;
    live = 0; pend = 0; busy_on = 0;
    e_x = 0; e_y = 0; e_val = 0;
    for (int i = 0; i < 4; i++) e_bb[i] = 0;
  endtask

  task automatic model_pixel(input bit fs, input bit m, input int t);
    if (fs) begin
      mx = 0; my = 0; live = 1; mcnt = 0; msx = 0; msy = 0;
      mxmin = 1000; mxmax = -1; mymin = 1000; mymax = -1;
    end
    if (live && m) begin
      mcnt++; msx += mx; msy += my;
      if (mx < mxmin) mxmin = mx;
      if (mx > mxmax) mxmax = mx;
      if (my < mymin) mymin = my;
      if (my > mymax) mymax = my;
    end
    if (live && mx == W-1 && my == H-1) begin
      live = 0; pend = 1; pend_cyc = t + 5; busy_on = 1; busy_t = t; last_t = t;
      pend_val = (mcnt >= MINP);
      if (pend_val) begin
        pend_x = msx / mcnt;
        pend_y = msy / mcnt;
        pend_bb[0] = BBOX ? mxmin : 0;
        pend_bb[1] = BBOX ? mxmax : 0;
        pend_bb[2] = BBOX ? mymin : 0;
        pend_bb[3] = BBOX ? mymax : 0;
      end
    end
    if (mx == W-1) begin
      mx = 0;
      my = (my == H-1) ? 0 : my + 1;
    end else begin
      mx++;
    end
  endtask

  always @(negedge clk) begin
    bit es, eb;
    if (chk_en) begin
      es = pend && cyc == pend_cyc;
      if (es) begin
        pend = 0;
        e_val = pend_val;
        if (pend_val) begin
          e_x = pend_x; e_y = pend_y;
          for (int i = 0; i < 4; i++) e_bb[i] = pend_bb[i];
        end
      end
      eb = busy_on && cyc >= busy_t && cyc <= busy_t + 2;
      chk("stb", bus.oCent_Stb, es);
      chk("busy", bus.oBusy, eb);
      chk("val", bus.oCent_Val, e_val);
      chk("cx", bus.oCent_X, e_x);
      chk("cy", bus.oCent_Y, e_y);
      chk("xmin", bus.oBox_Xmin, e_bb[0]);
      chk("xmax", bus.oBox_Xmax, e_bb[1]);
      chk("ymin", bus.oBox_Ymin, e_bb[2]);
      chk("ymax", bus.oBox_Ymax, e_bb[3]);
      if (bus.oCent_Stb === 1'b1) begin
        if (stb_seen < 32) begin
          cap_x[stb_seen]    = bus.oCent_X;
          cap_y[stb_seen]    = bus.oCent_Y;
          cap_val[stb_seen]  = bus.oCent_Val;
          cap_cyc[stb_seen]  = cyc;
          cap_xmin[stb_seen] = bus.oBox_Xmin;
          cap_ymax[stb_seen] = bus.oBox_Ymax;
        end
        stb_seen++;
      end
    end
  end

  task automatic drive(input bit v, input bit fs, input bit m);
    int t;
    @(negedge clk);
    bus.iPix_Val = v; bus.iFrame_Start = fs; bus.iMatch = m;
    t = cyc + 1;
    @(posedge clk);
    if (v) model_pixel(fs, m, t);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  // Drives pixels 0..stop_at-1 in raster order, frame start on pixel 0, optional random gaps.
  task automatic frame(input logic [31:0] mask, input int gap_max, input int stop_at);
    for (int i = 0; i < stop_at; i++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, i == 0, mask[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.iPix_Val = 1'b0; bus.iFrame_Start = 1'b0; bus.iMatch = 1'b0;
    @(posedge clk);
    model_reset();
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int s0, ta, tb;
    chk_en = 1'b0;
    bus.iPix_Val = 1'b0; bus.iFrame_Start = 1'b0; bus.iMatch = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();
    chk("rst_x", bus.oCent_X, 0);
    chk("rst_y", bus.oCent_Y, 0);
    chk("rst_val", bus.oCent_Val, 0);
    chk("rst_stb", bus.oCent_Stb, 0);
    chk("rst_busy", bus.oBusy, 0);
    idle(3);

    // (2,1),(4,1),(3,3) then, back to back, only (5,2)
    s0 = stb_seen;
    frame(32'h0800_1400, 0, 32); ta = last_t;
    frame(32'h0020_0000, 0, 32); tb = last_t;
    idle(8);
    @(negedge clk);
    chk("s12_nstb", stb_seen - s0, 2);
    chk("s1_x", cap_x[s0], 3);
    chk("s1_y", cap_y[s0], 1);
    chk("s1_val", cap_val[s0], 1);
    chk("s1_lat", cap_cyc[s0] - ta, 5);
    chk("s1_xmin", cap_xmin[s0], BBOX ? 2 : 0);
    chk("s1_ymax", cap_ymax[s0], BBOX ? 3 : 0);
    chk("s2_val", cap_val[s0+1], 0);
    chk("s2_x", cap_x[s0+1], 3);
    chk("s2_y", cap_y[s0+1], 1);
    chk("s2_lat", cap_cyc[s0+1] - tb, 5);
    chk("s2_xmax", bus.oBox_Xmax, BBOX ? 4 : 0);

    // (1,0),(2,0) with random gaps
    s0 = stb_seen;
    frame(32'h0000_0006, 3, 32); ta = last_t;
    idle(8);
    @(negedge clk);
    chk("s3_x", bus.oCent_X, 1);
    chk("s3_y", bus.oCent_Y, 0);
    chk("s3_val", bus.oCent_Val, 1);
    chk("s3_lat", cap_cyc[s0] - ta, 5);

    // abort at (3,2), then a frame with (0,3),(2,3)
    s0 = stb_seen;
    frame(32'h0000_8040, 0, 19);
    frame(32'h0500_0000, 0, 32);
    idle(8);
    @(negedge clk);
    chk("s5_nstb", stb_seen - s0, 1);
    chk("s5_x", bus.oCent_X, 1);
    chk("s5_y", bus.oCent_Y, 3);
    chk("s5_ymin", bus.oBox_Ymin, BBOX ? 3 : 0);

    // reset while dividing
    s0 = stb_seen;
    frame(32'h0000_0300, 0, 32);
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("s6_busy", bus.oBusy, 1);
    do_reset();
    chk("s6_x", bus.oCent_X, 0);
    chk("s6_y", bus.oCent_Y, 0);
    chk("s6_val", bus.oCent_Val, 0);
    chk("s6_busy0", bus.oBusy, 0);
    chk("s6_xmax", bus.oBox_Xmax, 0);
    idle(8);
    @(negedge clk);
    chk("s6_nstb", stb_seen - s0, 0);

    // valid frame (0,0),(7,3), then a frame with no matches
    frame(32'h8000_0001, 0, 32);
    idle(8);
    @(negedge clk);
    chk("s7_x", bus.oCent_X, 3);
    chk("s7_y", bus.oCent_Y, 1);
    chk("s7_val", bus.oCent_Val, 1);
    frame(32'h0000_0000, 0, 32);
    @(negedge clk);
    bus.iPix_Val = 1'b0;
    repeat (4) @(negedge clk);
    chk("s8_pre_val", bus.oCent_Val, 1);
    chk("s8_pre_stb", bus.oCent_Stb, 0);
    @(negedge clk);
    chk("s8_stb", bus.oCent_Stb, 1);
    chk("s8_val", bus.oCent_Val, 0);
    chk("s8_x_held", bus.oCent_X, 3);
    @(negedge clk);
    chk("s8_stb_w", bus.oCent_Stb, 0);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/centroid_calc.md
# centroid_calc

Producer of the `oCent_Val` detection flag and centroid coordinates consumed by the on-screen tracking buffer and the overlay logic. It accumulates the coordinates of colour-matched pixels over one video frame. At end of frame it runs a sequential restoring divider to produce the mean X/Y. It then publishes a per-frame detection result that is held until the next frame completes.

## Interface
- `IMG_WIDTH`, 640, active pixels per line
- `IMG_HEIGHT`, 480, active lines per frame
- `MIN_PIXELS`, 16, minimum matched-pixel count for a detection
- Derived, not overridable:
  - `X_W` = $clog2(IMG_WIDTH)
  - `Y_W` = $clog2(IMG_HEIGHT)
  - `CNT_W` = $clog2(IMG_WIDTH*IMG_HEIGHT+1)
  - `SX_W` = X_W+CNT_W
  - `SY_W` = Y_W+CNT_W
  - `DIV_ITERS` = max(X_W, Y_W)

- `clk` in 1: single clock
- `rst_n` in 1: reset, synchronous, active-low
- `iPix_Val` in 1: pixel present this cycle
- `iFrame_Start` in 1: qualifies first pixel of a frame; only sampled when `iPix_Val`=1
- `iMatch` in 1: pixel passes colour threshold; only sampled when `iPix_Val`=1
- `oCent_X` out X_W: centroid X, floor(sum_x/count)
- `oCent_Y` out Y_W: centroid Y, floor(sum_y/count)
- `oCent_Val` out 1: level; 1 = last completed frame had count ≥ MIN_PIXELS
- `oCent_Stb` out 1: one-cycle pulse when a frame result is published
- `oBusy` out 1: divider running
- `oBox_Xmin`, `oBox_Xmax` out X_W: bounding box X limits
- `oBox_Ymin`, `oBox_Ymax` out Y_W: bounding box Y limits

## Operation
- Internal x/y position counters advance only on `iPix_Val`=1, raster order: x wraps at IMG_WIDTH-1, then y increments.
- `iPix_Val`=1 and `iFrame_Start`=1 forces the position to (0,0) and clears all accumulators (count, sum_x, sum_y, bbox). That pixel is then accumulated normally.
- Accumulate on `iMatch`:
  - count += 1
  - sum_x += x
  - sum_y += y
- Last pixel = (IMG_WIDTH-1, IMG_HEIGHT-1). On it:
  - count, sums and bbox are latched into divider registers.
  - Accumulators are cleared.
  - FSM moves ACCUM→DIVIDE.
- Pixels arriving after the last pixel and before the next `iFrame_Start` are ignored (state IDLE).
- FSM states: IDLE → (frame start) ACCUM → (last pixel) DIVIDE → (DIV_ITERS cycles) PUBLISH → IDLE.
  - Accumulation of a new frame may begin while in DIVIDE or PUBLISH.
- DIVIDE: two restoring dividers run in parallel, one quotient bit per cycle, MSB first, for DIV_ITERS iterations.
- PUBLISH:
  - If latched count ≥ MIN_PIXELS: load `oCent_X`/`oCent_Y` with the quotients, `oCent_Val`=1, and load the bbox outputs.
  - Otherwise: `oCent_Val`=0; X, Y and bbox outputs hold their previous values.
  - `oCent_Stb`=1 in either case.
- `iFrame_Start` while in ACCUM aborts the frame. No publish occurs, and the outputs are unchanged.
- Quotients are truncated to X_W/Y_W bits; the mean is always less than the dimension, so no overflow is possible.

## Timing
- All outputs are registered.
- Reset values:
  - `oCent_X`, `oCent_Y`, `oCent_Val`, `oCent_Stb`, `oBusy` = 0
  - bbox outputs = 0
  - FSM = IDLE
  - all counters and accumulators = 0
- Reset asserted mid-DIVIDE or mid-ACCUM discards everything; no `oCent_Stb` follows.
- Let T be the edge sampling the last pixel:
  - `oBusy`=1 during cycles T+1 … T+DIV_ITERS.
  - Outputs update and `oCent_Stb`=1 on edge T+DIV_ITERS+2.
- Latency is constant regardless of count, including count=0. For 640×480 the latency is 12 cycles.
- A last pixel arriving while still DIVIDE/PUBLISH from the previous frame cannot occur, since the minimum frame length exceeds the latency; this is not handled.

## Configuration
- `CENT_BBOX_EN` defined:
  - min/max x and y of matched pixels are tracked per frame and published with the centroid.
  - On a fresh frame, min registers are cleared to all-ones and max registers to 0.
- Not defined:
  - No bbox logic is built.
  - `oBox_*` ports remain and are tied to 0.

## Test plan
All scenarios use IMG_WIDTH=8, IMG_HEIGHT=4, MIN_PIXELS=2 (DIV_ITERS=3, latency 5).
- Continuous frame matching (2,1), (4,1), (3,3) → `oCent_Stb` 5 cycles after the last pixel; X=3, Y=1, Val=1. With `CENT_BBOX_EN`: Xmin=2, Xmax=4, Ymin=1, Ymax=3.
- Next frame matching only (5,2) → Stb pulses; Val=0; X=3, Y=1 held.
- Frame matching (1,0), (2,0) with random `iPix_Val` gaps → X=1 (floor of 1.5), Y=0, Val=1; latency still 5 cycles from the last valid pixel.
- `iFrame_Start` reasserted at pixel (3,2) of a frame containing matches → no Stb for the aborted frame; the following result reflects only the new frame.
- `rst_n`=0 for one cycle while `oBusy`=1 → no Stb, and all outputs read 0 the cycle after reset.
- Frame with zero matches after a valid frame → Val falls to 0 exactly on the Stb cycle; Stb width is 1 cycle.
